// File: rtl/instr_pkg.sv
// -----------------------------------------------------------------------------
// instr_pkg
// Shared definitions for the 32-bit instruction word used by the encoder that
// loads instruction memory and by the control unit's decoder.
//   - field MSB/LSB positions and field widths
//   - FSM state type for the encoder's memory-write sequencer
//   - pack_word(): assembles a full instruction word from its fields
// Optional feature macro: INSTR_ENC_PARITY_EN
//   defined   -> bit 23 carries even parity over the whole word
//   undefined -> bit 23 is tied to 0 and no parity logic is built
// -----------------------------------------------------------------------------
package instr_pkg;

    localparam int WORD_W = 32;
    localparam int OPC_W  = 4;
    localparam int NUM_W  = 8;
    localparam int REG_W  = 5;

    localparam int OPC_MSB    = 31;
    localparam int OPC_LSB    = 28;
    localparam int NUM_MSB    = 22;
    localparam int NUM_LSB    = 15;
    localparam int A3_MSB     = 14;
    localparam int A3_LSB     = 10;
    localparam int A2_MSB     = 9;
    localparam int A2_LSB     = 5;
    localparam int A1_MSB     = 4;
    localparam int A1_LSB     = 0;
    localparam int PARITY_BIT = 23;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } enc_state_t;

    // Bits 27:24 are reserved and always zero. The parity bit is computed
    // over the word while bit 23 is still zero, which makes the XOR of all
    // 32 bits of the final word come out even.
    function automatic logic [WORD_W-1:0] pack_word(
        input logic [OPC_W-1:0] opc,
        input logic [NUM_W-1:0] num,
        input logic [REG_W-1:0] a3,
        input logic [REG_W-1:0] a2,
        input logic [REG_W-1:0] a1
    );
        logic [WORD_W-1:0] w;
        w                  = '0;
        w[OPC_MSB:OPC_LSB] = opc;
        w[NUM_MSB:NUM_LSB] = num;
        w[A3_MSB:A3_LSB]   = a3;
        w[A2_MSB:A2_LSB]   = a2;
        w[A1_MSB:A1_LSB]   = a1;
`ifdef INSTR_ENC_PARITY_EN
        w[PARITY_BIT]      = ^w;
`endif
        return w;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// -----------------------------------------------------------------------------
// instr_fifo
// Synchronous FIFO holding finished instruction words between the field
// input and the memory write port.
// Parameters: DEPTH (power of two, >= 2), WIDTH
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clear         synchronous flush (beats push and pop)
//   push, wdata   write side; ignored when full
//   pop           read side; ignored when empty
//   rdata         head entry (valid when !empty)
//   full, empty   status flags
//   count         number of stored entries
// -----------------------------------------------------------------------------
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    assign full  = (cnt == (PW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign rdata = store[rd_ptr];

    // Storage needs no reset: an entry is only ever read after it is written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Program-loading path in front of instruction memory. Packs instruction
// fields into 32-bit words, buffers them in a FIFO and writes them to memory
// at consecutive addresses starting from 0, stopping once the top address
// has been written.
// Parameters: FIFO_DEPTH (power of two, >= 2), MEM_AW (memory address width)
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   clear                    synchronous flush of FIFO and write address
//   in_valid, in_ready       field-set handshake
//   opcode, number,
//   addr3, addr2, addr1      instruction fields
//   mem_we, mem_ready        memory write handshake
//   mem_addr, mem_wdata      write address and packed word
//   mem_full                 every memory location has been written
//   words_written            completed write count
// Optional feature macro: INSTR_ENC_PARITY_EN (even parity in bit 23)
// -----------------------------------------------------------------------------
module instr_encoder
    import instr_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_AW     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [NUM_W-1:0]  number,
    input  logic [REG_W-1:0]  addr3,
    input  logic [REG_W-1:0]  addr2,
    input  logic [REG_W-1:0]  addr1,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_full,
    output logic [MEM_AW:0]   words_written
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    enc_state_t        state;
    enc_state_t        state_next;
    logic [WORD_W-1:0] packed_word;
    logic [WORD_W-1:0] head_word;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [MEM_AW-1:0] wr_ptr;
    logic [MEM_AW:0]   wr_count;
    logic              push;
    logic              pop;
    logic              write_done;
    logic              at_top;

    assign packed_word = pack_word(opcode, number, addr3, addr2, addr1);

    // clear blocks the input so a field set offered alongside it is dropped.
    assign in_ready   = !fifo_full && (state != ST_FULL) && !clear;
    assign push       = in_valid && in_ready;
    assign mem_we     = !fifo_empty && (state != ST_FULL);
    assign write_done = mem_we && mem_ready;
    assign pop        = write_done && !clear;
    assign at_top     = (wr_ptr == {MEM_AW{1'b1}});

    // Word output is zeroed whenever no write is requested so the bus reads
    // 0 out of reset and in FULL rather than exposing stale FIFO contents.
    assign mem_addr      = wr_ptr;
    assign mem_wdata     = mem_we ? head_word : '0;
    assign mem_full      = (state == ST_FULL);
    assign words_written = wr_count;

    instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .wdata (packed_word),
        .rdata (head_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (push) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (pop && at_top) begin
                    state_next = ST_FULL;
                end else if (pop && !push && (fifo_count == CNT_W'(1))) begin
                    state_next = ST_IDLE;
                end
            end
            ST_FULL: begin
                state_next = ST_FULL;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (clear) begin
            state_next = ST_IDLE;
        end
    end

    // The address wraps to 0 after the top write; FULL then prevents any
    // further writes until clear or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            wr_count <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            wr_count <= '0;
        end else if (pop) begin
            wr_ptr   <= wr_ptr + MEM_AW'(1);
            wr_count <= wr_count + (MEM_AW+1)'(1);
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Self-checking bench for instr_encoder (FIFO_DEPTH=4, MEM_AW=2). Accepted
// field sets push their hand-computed word and address into a scoreboard;
// a monitor pops and compares on every completed memory write.
// Expected words follow INSTR_ENC_PARITY_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

    localparam int FIFO_DEPTH = 4;
    localparam int MEM_AW     = 2;
    localparam int MEM_WORDS  = 1 << MEM_AW;

    typedef struct packed {
        logic [3:0]  opc;
        logic [7:0]  num;
        logic [4:0]  a3;
        logic [4:0]  a2;
        logic [4:0]  a1;
        logic [31:0] word;
    } vec_t;

    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic [31:0]       data;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        opcode;
    logic [7:0]        number;
    logic [4:0]        addr3;
    logic [4:0]        addr2;
    logic [4:0]        addr1;
    logic              mem_we;
    logic              mem_ready;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_full;
    logic [MEM_AW:0]   words_written;

    vec_t vecs [7];
    exp_t sb [$];
    exp_t mon_e;
    int   sb_next_addr;
    int   check_count;
    int   pass_count;
    bit   acc;

    instr_encoder #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .MEM_AW     (MEM_AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opcode        (opcode),
        .number        (number),
        .addr3         (addr3),
        .addr2         (addr2),
        .addr1         (addr1),
        .mem_we        (mem_we),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_full      (mem_full),
        .words_written (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [3:0] opc, input logic [7:0] num,
                                input logic [4:0] a3, input logic [4:0] a2,
                                input logic [4:0] a1, input logic [31:0] w_plain,
                                input logic [31:0] w_par);
        vec_t v;
        v.opc = opc;
        v.num = num;
        v.a3  = a3;
        v.a2  = a2;
        v.a1  = a1;
`ifdef INSTR_ENC_PARITY_EN
        v.word = w_par;
`else
        v.word = w_plain;
`endif
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end else begin
            pass_count++;
        end
    endtask

    task automatic setFields(input int idx);
        opcode = vecs[idx].opc;
        number = vecs[idx].num;
        addr3  = vecs[idx].a3;
        addr2  = vecs[idx].a2;
        addr1  = vecs[idx].a1;
    endtask

    // Entered and left at posedge+1; offers one field set for one cycle.
    task automatic applyStimulus(input int idx, output bit accepted);
        setFields(idx);
        in_valid = 1'b1;
        @(negedge clk);
        accepted = in_ready;
        if (accepted && sb_next_addr < MEM_WORDS) begin
            sb.push_back('{addr: sb_next_addr[MEM_AW-1:0], data: vecs[idx].word});
            sb_next_addr++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst      = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        sb_next_addr = 0;
        @(negedge clk);
        nextCycle();
        rst = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            nextCycle();
            n++;
        end
        checkOutput("drain_remaining", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && mem_we && mem_ready) begin
            if (sb.size() == 0) begin
                check_count++;
                $display("[TB] FAIL unexpected_write: addr %0d data 0x%08h, required no write",
                         mem_addr, mem_wdata);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("write_addr", 32'(mem_addr), 32'(mon_e.addr));
                checkOutput("write_data", mem_wdata, mon_e.data);
            end
        end
    end

    initial begin
        check_count  = 0;
        pass_count   = 0;
        sb_next_addr = 0;
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        mem_ready = 1'b0;
        opcode    = '0;
        number    = '0;
        addr3     = '0;
        addr2     = '0;
        addr1     = '0;

        vecs[0] = mk(4'hA, 8'h5C, 5'd3,  5'd17, 5'd9,  32'hA02E0E29, 32'hA02E0E29);
        vecs[1] = mk(4'hF, 8'hFF, 5'd31, 5'd31, 5'd31, 32'hF07FFFFF, 32'hF0FFFFFF);
        vecs[2] = mk(4'h1, 8'h00, 5'd0,  5'd0,  5'd1,  32'h10000001, 32'h10000001);
        vecs[3] = mk(4'h2, 8'h01, 5'd0,  5'd0,  5'd2,  32'h20008002, 32'h20808002);
        vecs[4] = mk(4'h3, 8'h00, 5'd1,  5'd0,  5'd0,  32'h30000400, 32'h30800400);
        vecs[5] = mk(4'h4, 8'h00, 5'd0,  5'd1,  5'd0,  32'h40000020, 32'h40000020);
        vecs[6] = mk(4'h8, 8'h80, 5'd0,  5'd0,  5'd31, 32'h8040001F, 32'h80C0001F);

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_mem_full", 32'(mem_full), 32'd0);
        checkOutput("rst_words_written", 32'(words_written), 32'd0);
        nextCycle();
        rst = 1'b0;

        // Basic pack and one-cycle latency
        $display("[TB] basic pack");
        mem_ready = 1'b1;
        applyStimulus(0, acc);
        checkOutput("basic_accept", 32'(acc), 32'd1);
        @(negedge clk);
        checkOutput("basic_latency_we", 32'(mem_we), 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("basic_we_drop", 32'(mem_we), 32'd0);
        checkOutput("basic_words_written", 32'(words_written), 32'd1);
        nextCycle();

        // All fields at maximum exercises the parity bit
        $display("[TB] parity");
        applyStimulus(1, acc);
        waitDrain(4);
        doReset();

        // Backpressure: FIFO fills, outputs hold, then drains in order
        $display("[TB] backpressure");
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2 + i, acc);
            checkOutput("bp_accept", 32'(acc), 32'd1);
        end
        applyStimulus(6, acc);
        checkOutput("bp_fifth_blocked", 32'(acc), 32'd0);
        @(negedge clk);
        checkOutput("bp_hold_we", 32'(mem_we), 32'd1);
        checkOutput("bp_hold_addr", 32'(mem_addr), 32'd0);
        checkOutput("bp_hold_data", mem_wdata, vecs[2].word);
        nextCycle();
        mem_ready = 1'b1;
        begin
            int tries;
            tries = 0;
            do begin
                applyStimulus(6, acc);
                tries++;
            end while (!acc && tries < 8);
        end
        checkOutput("bp_fifth_accept", 32'(acc), 32'd1);
        waitDrain(10);
        nextCycle();
        @(negedge clk);
        checkOutput("bp_mem_full", 32'(mem_full), 32'd1);
        checkOutput("bp_full_we", 32'(mem_we), 32'd0);
        nextCycle();
        doReset();

        // Fill memory, then clear
        $display("[TB] fill and clear");
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2 + (i % 5), acc);
        end
        nextCycle();
        @(negedge clk);
        checkOutput("fill_mem_full", 32'(mem_full), 32'd1);
        checkOutput("fill_words_written", 32'(words_written), 32'd4);
        checkOutput("fill_in_ready", 32'(in_ready), 32'd0);
        checkOutput("fill_mem_we", 32'(mem_we), 32'd0);
        checkOutput("fill_all_written", 32'(sb.size()), 32'd0);
        nextCycle();
        clear = 1'b1;
        @(negedge clk);
        checkOutput("clear_in_ready_low", 32'(in_ready), 32'd0);
        nextCycle();
        clear = 1'b0;
        sb.delete();
        sb_next_addr = 0;
        @(negedge clk);
        checkOutput("clear_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("clear_mem_full", 32'(mem_full), 32'd0);
        checkOutput("clear_in_ready", 32'(in_ready), 32'd1);
        nextCycle();
        doReset();

        // Push and pop in the same cycle keep the count at 2
        $display("[TB] simultaneous push/pop");
        mem_ready = 1'b0;
        applyStimulus(2, acc);
        applyStimulus(3, acc);
        mem_ready = 1'b1;
        applyStimulus(4, acc);
        checkOutput("sim_pushpop_accept", 32'(acc), 32'd1);
        mem_ready = 1'b0;
        applyStimulus(5, acc);
        checkOutput("sim_third_accept", 32'(acc), 32'd1);
        applyStimulus(6, acc);
        checkOutput("sim_fourth_accept", 32'(acc), 32'd1);
        applyStimulus(2, acc);
        checkOutput("sim_fifo_full_block", 32'(acc), 32'd0);
        mem_ready = 1'b1;
        waitDrain(10);
        doReset();

        // clear with push: the pushed word must never reach memory
        $display("[TB] clear with push");
        mem_ready = 1'b1;
        setFields(6);
        clear    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        checkOutput("clrpush_in_ready", 32'(in_ready), 32'd0);
        nextCycle();
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("clrpush_discarded", 32'(mem_we), 32'd0);
        nextCycle();
        applyStimulus(2, acc);
        waitDrain(4);
        doReset();

        // Reset in the middle of a stalled write
        $display("[TB] reset mid-write");
        mem_ready = 1'b0;
        applyStimulus(3, acc);
        @(negedge clk);
        checkOutput("midrst_we_before", 32'(mem_we), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("midrst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("midrst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_mem_full", 32'(mem_full), 32'd0);
        checkOutput("midrst_words_written", 32'(words_written), 32'd0);
        sb.delete();
        sb_next_addr = 0;
        nextCycle();
        rst = 1'b0;
        nextCycle();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
